// File: rtl/door_lock_ctrl.sv
// Smart-lock bolt controller: conditions two asynchronous level commands into
// single-cycle pulses and sequences the bolt actuator through timed moves.

module door_lock_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic s1_q, s2_q, s3_q;

  // s1/s2 resolve metastability; s3 is history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse = s2_q & ~s3_q;
endmodule

// state      | meaning
// UNLOCKED   | bolt retracted, idle; lock pulse or relock timeout starts LOCKING
// LOCKING    | motor_lock driven for ACT_CYCLES cycles
// LOCKED     | bolt thrown, idle; unlock pulse starts UNLOCKING
// UNLOCKING  | motor_unlock driven for ACT_CYCLES cycles, bolt still reported thrown
module door_lock_ctrl #(
  parameter int ACT_CYCLES         = 4,
  parameter int AUTO_RELOCK_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic lock,
  input  logic unlock,
  output logic doorLocked,
  output logic motor_lock,
  output logic motor_unlock,
  output logic busy
);
  localparam int MAX_CNT = (ACT_CYCLES > AUTO_RELOCK_CYCLES) ? ACT_CYCLES : AUTO_RELOCK_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam bit AUTO_EN = (AUTO_RELOCK_CYCLES > 0);
  localparam logic [CW-1:0] ACT_LOAD  = CW'(ACT_CYCLES - 1);
  localparam logic [CW-1:0] RELOCK_TC = AUTO_EN ? CW'(AUTO_RELOCK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_LOCKING   = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_UNLOCKING = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   act_cnt_q, act_cnt_d;
  logic [CW-1:0]   relock_cnt_q, relock_cnt_d;
  logic            lock_pulse, unlock_pulse;

  door_lock_edge u_lock_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (lock),
    .pulse (lock_pulse)
  );

  door_lock_edge u_unlock_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (unlock),
    .pulse (unlock_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      act_cnt_q    <= '0;
      relock_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      act_cnt_q    <= act_cnt_d;
      relock_cnt_q <= relock_cnt_d;
    end
  end

  // Relock count defaults to zero so it is already cleared on entry to UNLOCKED
  always_comb begin
    state_d      = state_q;
    act_cnt_d    = act_cnt_q;
    relock_cnt_d = '0;
    unique case (state_q)
      ST_UNLOCKED: begin
        if (lock_pulse) begin
          state_d   = ST_LOCKING;
          act_cnt_d = ACT_LOAD;
        end else if (unlock_pulse) begin
          relock_cnt_d = '0;
        end else if (AUTO_EN && (relock_cnt_q == RELOCK_TC)) begin
          state_d   = ST_LOCKING;
          act_cnt_d = ACT_LOAD;
        end else if (AUTO_EN) begin
          relock_cnt_d = relock_cnt_q + 1'b1;
        end
      end
      ST_LOCKING: begin
        if (act_cnt_q == '0) state_d = ST_LOCKED;
        else act_cnt_d = act_cnt_q - 1'b1;
      end
      ST_LOCKED: begin
        // Conflicting simultaneous commands leave the bolt thrown
        if (unlock_pulse && !lock_pulse) begin
          state_d   = ST_UNLOCKING;
          act_cnt_d = ACT_LOAD;
        end
      end
      ST_UNLOCKING: begin
        if (act_cnt_q == '0) state_d = ST_UNLOCKED;
        else act_cnt_d = act_cnt_q - 1'b1;
      end
    endcase
  end

  always_comb begin
    doorLocked   = (state_q == ST_LOCKED) || (state_q == ST_UNLOCKING);
    motor_lock   = (state_q == ST_LOCKING);
    motor_unlock = (state_q == ST_UNLOCKING);
    busy         = (state_q == ST_LOCKING) || (state_q == ST_UNLOCKING);
  end

  a_motor_excl: assert property (@(posedge clk) disable iff (rst) !(motor_lock && motor_unlock));
endmodule

// File: tb/tb_door_lock_ctrl.sv
// Randomized scoreboard bench for door_lock_ctrl across three parameter sets,
// checked against a timestamp-based bolt model.
module tb_door_lock_ctrl;
  localparam int NI = 3;
  localparam int ACTP  [NI] = '{4, 4, 1};
  localparam int AUTOP [NI] = '{0, 10, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lock = 1'b0;
  logic unlock = 1'b0;
  logic dl [NI];
  logic ml [NI];
  logic mu [NI];
  logic bz [NI];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  door_lock_ctrl #(.ACT_CYCLES(4), .AUTO_RELOCK_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .lock(lock), .unlock(unlock),
    .doorLocked(dl[0]), .motor_lock(ml[0]), .motor_unlock(mu[0]), .busy(bz[0]));
  door_lock_ctrl #(.ACT_CYCLES(4), .AUTO_RELOCK_CYCLES(10)) u1 (
    .clk(clk), .rst(rst), .lock(lock), .unlock(unlock),
    .doorLocked(dl[1]), .motor_lock(ml[1]), .motor_unlock(mu[1]), .busy(bz[1]));
  door_lock_ctrl #(.ACT_CYCLES(1), .AUTO_RELOCK_CYCLES(1)) u2 (
    .clk(clk), .rst(rst), .lock(lock), .unlock(unlock),
    .doorLocked(dl[2]), .motor_lock(ml[2]), .motor_unlock(mu[2]), .busy(bz[2]));

  // Reference model: bolt position, remaining move time, and the timestamp at
  // which the current idle-unlocked period began.
  longint n_edge = 0;
  logic [2:0] hl = '0;
  logic [2:0] hu = '0;
  bit     bolt   [NI];
  int     remain [NI];
  bit     tgt    [NI];
  longint ref_t  [NI];
  logic [4*NI-1:0] exp_q [$];

  task automatic start_move(int i, bit to_locked);
    remain[i] = ACTP[i];
    tgt[i]    = to_locked;
  endtask

  task automatic model_edge();
    bit lp, up;
    n_edge++;
    if (rst) begin
      hl = '0;
      hu = '0;
      for (int i = 0; i < NI; i++) begin
        bolt[i] = 1'b0; remain[i] = 0; tgt[i] = 1'b0; ref_t[i] = n_edge;
      end
    end else begin
      lp = hl[1] & ~hl[2];
      up = hu[1] & ~hu[2];
      hl = {hl[1:0], lock};
      hu = {hu[1:0], unlock};
      for (int i = 0; i < NI; i++) begin
        if (remain[i] > 0) begin
          remain[i]--;
          if (remain[i] == 0) begin
            bolt[i] = tgt[i];
            if (!tgt[i]) ref_t[i] = n_edge;
          end
        end else if (!bolt[i]) begin
          if (lp) start_move(i, 1'b1);
          else if (up) ref_t[i] = n_edge;
          else if (AUTOP[i] > 0 && (n_edge - ref_t[i]) >= AUTOP[i]) start_move(i, 1'b1);
        end else if (up && !lp) begin
          start_move(i, 1'b0);
        end
      end
    end
  endtask

  function automatic logic [4*NI-1:0] model_outputs();
    logic [4*NI-1:0] v;
    for (int i = 0; i < NI; i++)
      v[(NI-1-i)*4 +: 4] = {bolt[i], (remain[i] > 0) && tgt[i],
                            (remain[i] > 0) && !tgt[i], remain[i] > 0};
    return v;
  endfunction

  function automatic logic [3:0] dut_outputs(int i);
    return {dl[i], ml[i], mu[i], bz[i]};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      exp_q.push_back(model_outputs());
    end
  end

  // Monitor: every negedge the DUT presents a fresh set of registered outputs
  initial begin
    logic [4*NI-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          n_vec++;
          if (dut_outputs(i) !== e[(NI-1-i)*4 +: 4]) begin
            n_bad++;
            $display("FAIL outputs inst%0d t=%0t dl/ml/mu/busy got %b expected %b",
                     i, $time, dut_outputs(i), e[(NI-1-i)*4 +: 4]);
          end
        end
      end
    end
  end

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (dut_outputs(i) !== 4'b0000) begin
        n_bad++;
        $display("FAIL async_reset inst%0d t=%0t got %b expected 0000", i, $time, dut_outputs(i));
      end
    end
    lock = 1'b0;
    unlock = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic drive(bit l, bit u, int n);
    lock = l;
    unlock = u;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    drive(0, 0, 3);
    lock = 1'b1;
    do_reset();
    drive(0, 0, 10);
    // lock, hold, unlock, relock
    drive(1, 0, 24);
    drive(0, 0, 20);
    drive(0, 1, 20);
    drive(0, 0, 20);
    drive(1, 0, 20);
    drive(0, 0, 20);
    // unlock pulse issued while LOCKING is dropped
    drive(0, 1, 20);
    drive(0, 0, 20);
    drive(1, 0, 3);
    drive(1, 1, 20);
    drive(0, 0, 20);
    // simultaneous rise from UNLOCKED, then from LOCKED
    drive(0, 1, 20);
    drive(0, 0, 20);
    drive(1, 1, 20);
    drive(0, 0, 5);
    drive(1, 1, 20);
    drive(0, 0, 5);
    // unlock pulse part-way through the idle-unlocked period restarts the relock timer
    drive(0, 1, 3);
    drive(0, 0, 6);
    drive(0, 1, 30);
    drive(0, 0, 10);
    drive(1, 0, 20);
    drive(0, 0, 5);
    // reset in the middle of UNLOCKING
    drive(0, 1, 4);
    do_reset();
    drive(0, 0, 5);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else if (!lock && !unlock && $urandom_range(0, 19) == 0) begin
        drive(1, 1, 1);
      end else begin
        drive(($urandom_range(0, 7) == 0) ? !lock : lock,
              ($urandom_range(0, 7) == 0) ? !unlock : unlock, 1);
      end
    end
    drive(0, 0, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
